// File: rtl/iterative_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : iterative_magnitude_comparator
// Purpose  : Multi-cycle magnitude compare, CHUNK bits per clock, MSB first,
//            stopping at the first differing chunk.
// Revision : 1.0
// ============================================================================
module iterative_magnitude_comparator #(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             not_equal,
  output logic             less_than,
  output logic             greater_than
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] c_last_idx = IDXW'(NCHUNK - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_done;
  logic             r_ne;
  logic             r_lt;
  logic             r_gt;

  logic             w_eff_signed;
  logic [WIDTH-1:0] w_bias;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;

  assign w_eff_signed = signed_mode & SIGNED_EN;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    w_bias            = '0;
    w_bias[WIDTH-1]   = w_eff_signed;
  end

  // Operands shift left each step, so the chunk under test is always the top one.
  assign w_a_chunk = r_a[WIDTH-1 -: CHUNK];
  assign w_b_chunk = r_b[WIDTH-1 -: CHUNK];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_ne    <= 1'b0;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a ^ w_bias;
            r_b     <= b ^ w_bias;
            r_idx   <= c_last_idx;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_a_chunk != w_b_chunk) begin
            r_ne    <= 1'b1;
            r_lt    <= (w_a_chunk < w_b_chunk);
            r_gt    <= !(w_a_chunk < w_b_chunk);
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (r_idx == '0) begin
            r_ne    <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_a   <= r_a << CHUNK;
            r_b   <= r_b << CHUNK;
            r_idx <= r_idx - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready        = (r_state == IDLE);
  assign done         = r_done;
  assign not_equal    = r_ne;
  assign less_than    = r_lt;
  assign greater_than = r_gt;

endmodule
`default_nettype wire
